// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and cache bus bundle for the memory port arbiter
interface mem_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_gnt;
    logic [NUM_REQ-1:0]        req_done;
    logic [DATA_W-1:0]         req_rdata;

    logic                      cache_valid;
    logic                      cache_we;
    logic [ADDR_W-1:0]         cache_addr;
    logic [DATA_W-1:0]         cache_wdata;
    logic                      cache_hit;
    logic                      cache_ready;
    logic [DATA_W-1:0]         cache_rdata;

    // master = the arbiter, which drives the shared cache port
    modport master (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_gnt, req_done, req_rdata,
        output cache_valid, cache_we, cache_addr, cache_wdata,
        input  cache_hit, cache_ready, cache_rdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_gnt, req_done, req_rdata,
        input  cache_valid, cache_we, cache_addr, cache_wdata,
        output cache_hit, cache_ready, cache_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sequencer sharing one cache port among load/store requesters
module mem_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.master   bus,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   idx;
    logic               lat_we;
    logic [7:0]         cnt;

    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               cache_valid_q;
    logic               cache_we_q;
    logic [ADDR_W-1:0]  cache_addr_q;
    logic [DATA_W-1:0]  cache_wdata_q;

    logic               found;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   cand;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = bus.req_wdata[g*DATA_W +: DATA_W];
    end

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ-1)) ? '0 : i + IDX_W'(1);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Search starts one past the last winner so a requester that was just
    // serviced is considered last on the next arbitration.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        cand  = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = next_idx(cand);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= IDX_W'(NUM_REQ-1);
            idx           <= '0;
            lat_we        <= 1'b0;
            cnt           <= '0;
            gnt_q         <= '0;
            done_q        <= '0;
            rdata_q       <= '0;
            cache_valid_q <= 1'b0;
            cache_we_q    <= 1'b0;
            cache_addr_q  <= '0;
            cache_wdata_q <= '0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            done_q      <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        idx           <= win;
                        lat_we        <= bus.req_we[win];
                        cache_valid_q <= 1'b1;
                        cache_we_q    <= bus.req_we[win];
                        cache_addr_q  <= addr_arr[win];
                        cache_wdata_q <= wdata_arr[win];
                        gnt_q         <= onehot(win);
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    cache_valid_q <= 1'b0;
                    cache_we_q    <= 1'b0;
                    cache_addr_q  <= '0;
                    cache_wdata_q <= '0;
                    if (bus.cache_hit) begin
                        rdata_q <= lat_we ? '0 : bus.cache_rdata;
                        done_q  <= onehot(idx);
                        state   <= DONE;
                    end else begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.cache_ready) begin
                        rdata_q <= lat_we ? '0 : bus.cache_rdata;
                        done_q  <= onehot(idx);
                        state   <= DONE;
                    end else if (cnt == 8'(TIMEOUT-1)) begin
                        rdata_q     <= '0;
                        timeout_err <= 1'b1;
                        done_q      <= onehot(idx);
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    ptr   <= idx;
                    gnt_q <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_gnt     = gnt_q;
    assign bus.req_done    = done_q;
    assign bus.req_rdata   = rdata_q;
    assign bus.cache_valid = cache_valid_q;
    assign bus.cache_we    = cache_we_q;
    assign bus.cache_addr  = cache_addr_q;
    assign bus.cache_wdata = cache_wdata_q;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter and sequencer that shares the single core-to-cache memory port between up to NUM_REQ load/store requesters. Candidates are the per-core load and store units. It latches one request at a time and drives the cache address, write-enable and data lines. It waits for a hit or a fill-grant, then returns read data and a one-cycle completion pulse to the winning requester. It sits between the execute-stage memory units and the shared cache controller.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 12, address width
- DATA_W, 8, data width
- TIMEOUT, 15, max cycles in WAIT before forced completion (1..255)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_we  in  NUM_REQ  1 = store, 0 = load
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed store data
- req_gnt  out  NUM_REQ  one-hot; requester being serviced
- req_done  out  NUM_REQ  one-hot, one-cycle completion pulse
- req_rdata  out  DATA_W  load data, broadcast, valid with req_done
- cache_valid  out  1  one-cycle access strobe
- cache_we  out  1  access is a store
- cache_addr  out  ADDR_W  access address
- cache_wdata  out  DATA_W  store data
- cache_hit  in  1  same-cycle hit response to cache_valid
- cache_ready  in  1  miss serviced; cache_rdata valid
- cache_rdata  in  DATA_W  read data
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle pulse when a WAIT times out

## Operation
- FSM states are IDLE, ISSUE, WAIT and DONE.
- IDLE
  - If any req_valid bit is set, pick the first set bit searching from ptr+1 upward with wrap-around.
  - Latch the winner's index, req_we, req_addr and req_wdata, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE
  - cache_valid=1; cache_we, cache_addr and cache_wdata come from the latched values.
  - If cache_hit: capture cache_rdata and go to DONE.
  - Else: clear the timeout counter and go to WAIT.
- WAIT
  - All cache_* outputs are 0.
  - If cache_ready: capture cache_rdata and go to DONE.
  - Else if the counter equals TIMEOUT-1: set rdata to 0, pulse timeout_err, and go to DONE.
  - Else: increment the counter.
- DONE
  - req_done[idx]=1 for exactly one cycle.
  - ptr updates to idx.
  - Next state is IDLE.
- req_gnt[idx]=1 from ISSUE through DONE inclusive; it is 0 in IDLE.
- Stores: the captured rdata is forced to 0.
- req_rdata holds its last value until the next DONE.
- Inputs are sampled only in IDLE. A requester may change or drop req_valid at any other time with no effect on the access in flight.
- A requester must drop req_valid in the cycle after req_done, or it re-enters arbitration. Fairness holds because ptr has already moved past it.
- cache_hit is ignored outside ISSUE; cache_ready is ignored outside WAIT.
- Reset, asynchronous:
  - State goes to IDLE.
  - ptr = NUM_REQ-1, so the first search starts at requester 0.
  - All outputs, latches and the counter go to 0.
  - An access in flight is abandoned with no req_done.

## Timing
- All outputs are decoded from registers; there is no combinational input-to-output path.
- Hit latency: req_valid seen in IDLE at edge 0 → ISSUE in cycle 1 → req_done and req_rdata in cycle 2.
- Miss latency: cache_ready first high in WAIT cycle k → DONE in cycle k+1.
- Timeout: DONE occurs exactly TIMEOUT+2 cycles after the IDLE sample edge; timeout_err is coincident with entry to DONE.
- Back-to-back minimum is 3 cycles per hit access (IDLE, ISSUE, DONE); a new request is sampled in the IDLE cycle after DONE.
- Simultaneous requests: exactly one is granted per arbitration. With all NUM_REQ bits held high, grants rotate 0,1,2,3,0,...
- Reset released while req_valid is high: the first grant occurs in the cycle after reset deasserts.

## Test plan
- Single load hit: req 2, addr 0x3A5, hit=1 with rdata 0x5C → cache_valid 1 cycle with addr 0x3A5, we=0; req_done=0b0100 at cycle 2; req_rdata=0x5C.
- Store miss: req 1, we=1, addr 0x010, data 0xA7, hit=0, ready after 4 cycles → cache_we=1, cache_wdata=0xA7; req_done=0b0010 one cycle after ready; req_rdata=0.
- Fairness: all four requests held high for 8 accesses, all hits → grant order 0,1,2,3,0,1,2,3; req_gnt always one-hot.
- Timeout: TIMEOUT=15, load miss with ready never asserted → timeout_err and req_done together 17 cycles after the sample edge; req_rdata=0; the next request is then serviced normally.
- Reset mid-WAIT: assert rst asynchronously between edges → all outputs 0 immediately, no req_done; after release, req 3 alone is granted first and requester 0 next when both request.
- Late input change: req_addr and req_valid altered while in WAIT → cache_addr latched value unchanged and the access completes normally.
